// File: rtl/trivium_pkg.sv
// Shared constants, state encoding and tap positions for the Trivium stream engine.
// Tap constants use the 1-based Trivium numbering; the packed state holds s[i] at bit i-1.
package trivium_pkg;

    localparam int unsigned KEY_BITS   = 80;
    localparam int unsigned IV_BITS    = 80;
    localparam int unsigned STATE_BITS = 288;
    localparam int unsigned LOAD_BITS  = KEY_BITS + IV_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WARM = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int unsigned SIGN_LOADED  = 0;
    localparam int unsigned SIGN_WARM    = 1;
    localparam int unsigned SIGN_RUN     = 2;
    localparam int unsigned SIGN_OVERRUN = 3;

    localparam int unsigned T1_A     = 66;
    localparam int unsigned T1_B     = 93;
    localparam int unsigned T1_AND_A = 91;
    localparam int unsigned T1_AND_B = 92;
    localparam int unsigned T1_C     = 171;

    localparam int unsigned T2_A     = 162;
    localparam int unsigned T2_B     = 177;
    localparam int unsigned T2_AND_A = 175;
    localparam int unsigned T2_AND_B = 176;
    localparam int unsigned T2_C     = 264;

    localparam int unsigned T3_A     = 243;
    localparam int unsigned T3_B     = 288;
    localparam int unsigned T3_AND_A = 286;
    localparam int unsigned T3_AND_B = 287;
    localparam int unsigned T3_C     = 69;

    // Injection points of the three feedback bits after each shift.
    localparam int unsigned INJ_T3  = 1;
    localparam int unsigned INJ_T1  = 94;
    localparam int unsigned INJ_T2  = 178;

    localparam int unsigned IV_BASE = 94;
    localparam int unsigned ONES_LO = 286;

    // Fresh session state: all zero except s286..s288, with the first key bit in s1.
    function automatic logic [STATE_BITS-1:0] load_seed(input logic first_bit);
        logic [STATE_BITS-1:0] s;
        s = '0;
        s[ONES_LO-1 +: 3] = '1;
        s[0] = first_bit;
        return s;
    endfunction

endpackage

// File: rtl/trivium_step.sv
// Combinational N-step Trivium update: next state after N clocks of the cipher
// plus the N keystream bits produced on the way, first bit at the MSB.
module trivium_step
    import trivium_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [STATE_BITS-1:0] state_in,
    output logic [STATE_BITS-1:0] state_out,
    output logic [N-1:0]          ks
);

    always_comb begin
        logic [STATE_BITS-1:0] s;
        logic t1;
        logic t2;
        logic t3;
        s  = state_in;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        ks = '0;
        for (int unsigned i = 0; i < N; i++) begin
            t1 = s[T1_A-1] ^ s[T1_B-1];
            t2 = s[T2_A-1] ^ s[T2_B-1];
            t3 = s[T3_A-1] ^ s[T3_B-1];
            ks[N-1-i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[T1_AND_A-1] & s[T1_AND_B-1]) ^ s[T1_C-1];
            t2 = t2 ^ (s[T2_AND_A-1] & s[T2_AND_B-1]) ^ s[T2_C-1];
            t3 = t3 ^ (s[T3_AND_A-1] & s[T3_AND_B-1]) ^ s[T3_C-1];
            // One shift across all three registers, then overwrite each register head.
            s = {s[STATE_BITS-2:0], 1'b0};
            s[INJ_T3-1] = t3;
            s[INJ_T1-1] = t1;
            s[INJ_T2-1] = t2;
        end
        state_out = s;
    end

endmodule

// File: rtl/trivium_stream_xor.sv
// Trivium stream engine: serial key/IV load, warm-up, then DATA_W-bit XOR per
// accepted word with a single-entry output register and sticky overrun status.
module trivium_stream_xor
    import trivium_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WARM_ROUNDS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              KEY,
    input  logic              STB_KEY,
    input  logic [DATA_W-1:0] DATA,
    input  logic              STB_DATA,
    input  logic              READ,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              STB_READ,
    output logic              READY,
    output logic [7:0]        SIGN_REG
);

    localparam int unsigned WARM_CYCLES = WARM_ROUNDS * STATE_BITS / DATA_W;
    localparam int unsigned WCNT_W      = $clog2(WARM_CYCLES + 1);
    localparam int unsigned BCNT_W      = $clog2(LOAD_BITS);

    state_t                  state_q;
    state_t                  state_d;
    logic [BCNT_W-1:0]       bit_cnt_q;
    logic [WCNT_W-1:0]       warm_cnt_q;
    logic [STATE_BITS-1:0]   st_q;
    logic [STATE_BITS-1:0]   st_step;
    logic [DATA_W-1:0]       ks;
    logic [DATA_W-1:0]       data_out_q;
    logic                    stb_read_q;
    logic                    loaded_q;
    logic                    overrun_q;

    logic                    rekey;
    logic                    key_shift;
    logic                    last_bit;
    logic                    warm_done;
    logic                    accept;
    logic                    drop;
    logic [8:0]              wr_idx;

    trivium_step #(.N(DATA_W)) u_step (
        .state_in  (st_q),
        .state_out (st_step),
        .ks        (ks)
    );

    assign READY = (state_q == ST_RUN) && (!stb_read_q || READ);

    always_comb begin
        rekey     = STB_KEY && (state_q != ST_LOAD);
        key_shift = STB_KEY && (state_q == ST_LOAD);
        last_bit  = key_shift && (bit_cnt_q == BCNT_W'(LOAD_BITS - 1));
        warm_done = (state_q == ST_WARM) && (warm_cnt_q == WCNT_W'(WARM_CYCLES - 1));
        // A key strobe always wins over a coincident data word.
        accept    = STB_DATA && READY && !STB_KEY;
        drop      = STB_DATA && !READY && !STB_KEY;
        if (bit_cnt_q < BCNT_W'(KEY_BITS)) begin
            wr_idx = 9'(bit_cnt_q);
        end else begin
            wr_idx = 9'(bit_cnt_q) + 9'(IV_BASE - 1 - KEY_BITS);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (STB_KEY) state_d = ST_LOAD;
            ST_LOAD: if (last_bit) state_d = ST_WARM;
            ST_WARM: begin
                if (STB_KEY) begin
                    state_d = ST_LOAD;
                end else if (warm_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  if (STB_KEY) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_q       <= '0;
            bit_cnt_q  <= '0;
            warm_cnt_q <= '0;
            loaded_q   <= 1'b0;
        end else if (rekey) begin
            st_q      <= load_seed(KEY);
            bit_cnt_q <= BCNT_W'(1);
            loaded_q  <= 1'b0;
        end else if (key_shift) begin
            st_q[wr_idx] <= KEY;
            bit_cnt_q    <= bit_cnt_q + BCNT_W'(1);
            if (last_bit) begin
                loaded_q   <= 1'b1;
                warm_cnt_q <= '0;
            end
        end else if (state_q == ST_WARM) begin
            st_q       <= st_step;
            warm_cnt_q <= warm_cnt_q + WCNT_W'(1);
        end else if (accept) begin
            st_q <= st_step;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overrun_q <= 1'b0;
        end else if (rekey) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    // The output slot survives a rekey; only READ or a new word changes it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_out_q <= '0;
            stb_read_q <= 1'b0;
        end else if (accept) begin
            data_out_q <= DATA ^ ks;
            stb_read_q <= 1'b1;
        end else if (READ) begin
            stb_read_q <= 1'b0;
        end
    end

    assign DATA_OUT = data_out_q;
    assign STB_READ = stb_read_q;

    always_comb begin
        SIGN_REG               = '0;
        SIGN_REG[SIGN_LOADED]  = loaded_q;
        SIGN_REG[SIGN_WARM]    = (state_q == ST_WARM);
        SIGN_REG[SIGN_RUN]     = (state_q == ST_RUN);
        SIGN_REG[SIGN_OVERRUN] = overrun_q;
    end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Scoreboarded bench for trivium_stream_xor: an 8-bit and a 1-bit instance share
// the key interface and are checked against a bit-serial Trivium reference.
module tb_trivium_stream_xor;

    logic       CLK = 1'b0;
    logic       RST;
    logic       KEY;
    logic       STB_KEY;

    logic [7:0] DATA8;
    logic       STB_DATA8;
    logic       READ8;
    logic [7:0] DOUT8;
    logic       STB_READ8;
    logic       READY8;
    logic [7:0] SIGN8;

    logic [0:0] DATA1;
    logic       STB_DATA1;
    logic       READ1;
    logic [0:0] DOUT1;
    logic       STB_READ1;
    logic       READY1;
    logic [7:0] SIGN1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bit         ms [1:288];
    logic [7:0] q8 [$];
    logic [7:0] q1 [$];

    localparam logic [79:0] K1  = 80'h0F62B5085BAE0154A7FA;
    localparam logic [79:0] IV1 = 80'h288FF65DC42B92F960C7;
    localparam logic [79:0] K2  = 80'h1A2B3C4D5E6F70819203;
    localparam logic [79:0] IV2 = 80'hFEDCBA98765432100123;
    localparam logic [79:0] K3  = 80'h55555555555555555555;
    localparam logic [79:0] IV3 = 80'hA0A0A0A0A0A0A0A0A0A0;

    always #5 CLK = ~CLK;

    trivium_stream_xor #(.DATA_W(8), .WARM_ROUNDS(4)) dut8 (
        .CLK(CLK), .RST(RST), .KEY(KEY), .STB_KEY(STB_KEY),
        .DATA(DATA8), .STB_DATA(STB_DATA8), .READ(READ8),
        .DATA_OUT(DOUT8), .STB_READ(STB_READ8), .READY(READY8), .SIGN_REG(SIGN8)
    );

    trivium_stream_xor #(.DATA_W(1), .WARM_ROUNDS(4)) dut1 (
        .CLK(CLK), .RST(RST), .KEY(KEY), .STB_KEY(STB_KEY),
        .DATA(DATA1), .STB_DATA(STB_DATA1), .READ(READ1),
        .DATA_OUT(DOUT1), .STB_READ(STB_READ1), .READY(READY1), .SIGN_REG(SIGN1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference Trivium, written directly from the three-register description.
    task automatic model_step(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic model_load(input logic [79:0] k, input logic [79:0] iv);
        bit z;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ms[i+1]  = k[i];
            ms[94+i] = iv[i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int n = 0; n < 1152; n++) model_step(z);
    endtask

    task automatic model_byte(output logic [7:0] b);
        bit z;
        for (int i = 0; i < 8; i++) begin
            model_step(z);
            b[7-i] = z;
        end
    endtask

    // Serial load starting at bit index 'first'; K1 = k[0], IV1 = iv[0]; a few gaps.
    task automatic load_key(input logic [79:0] k, input logic [79:0] iv, input int first);
        logic b;
        for (int j = first; j < 160; j++) begin
            b = (j < 80) ? k[j] : iv[j-80];
            KEY = b;
            STB_KEY = 1'b1;
            tick();
            if (j % 37 == 5) begin
                STB_KEY = 1'b0;
                KEY = ~b;
                tick();
                tick();
            end
        end
        STB_KEY = 1'b0;
    endtask

    task automatic wait_run8(input string name);
        int unsigned n;
        n = 0;
        while (READY8 !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (READY8 !== 1'b1) $display("FAIL %s: READY8 timeout, got %b want 1", name, READY8);
        else n_pass++;
    endtask

    task automatic wait_run1(input string name);
        int unsigned n;
        n = 0;
        while (READY1 !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        n_checks++;
        if (READY1 !== 1'b1) $display("FAIL %s: READY1 timeout, got %b want 1", name, READY1);
        else n_pass++;
    endtask

    task automatic test_reset();
        RST = 1'b0; KEY = 1'b0; STB_KEY = 1'b0;
        DATA8 = '0; STB_DATA8 = 1'b0; READ8 = 1'b0;
        DATA1 = '0; STB_DATA1 = 1'b0; READ1 = 1'b0;
        tick();
        tick();
        n_checks++; if (SIGN8 !== 8'h00) $display("FAIL reset_sign: got %h want 00", SIGN8); else n_pass++;
        n_checks++; if (READY8 !== 1'b0) $display("FAIL reset_ready: got %b want 0", READY8); else n_pass++;
        n_checks++; if (STB_READ8 !== 1'b0) $display("FAIL reset_stb_read: got %b want 0", STB_READ8); else n_pass++;
        n_checks++; if (DOUT8 !== 8'h00) $display("FAIL reset_dout: got %h want 00", DOUT8); else n_pass++;
        n_checks++; if (SIGN1 !== 8'h00) $display("FAIL reset_sign1: got %h want 00", SIGN1); else n_pass++;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_load();
        for (int j = 0; j < 50; j++) begin
            KEY = 1'($urandom_range(1));
            STB_KEY = 1'b1;
            tick();
        end
        STB_KEY = 1'b0;
        n_checks++; if (SIGN8 !== 8'h00) $display("FAIL midload_sign: got %h want 00", SIGN8); else n_pass++;
        RST = 1'b0;
        tick();
        n_checks++; if (SIGN8 !== 8'h00) $display("FAIL midload_rst_sign: got %h want 00", SIGN8); else n_pass++;
        n_checks++; if (READY8 !== 1'b0) $display("FAIL midload_rst_ready: got %b want 0", READY8); else n_pass++;
        RST = 1'b1;
        tick();
        // Reset in the middle of warm-up must act without waiting for a clock edge.
        load_key(K2, IV2, 0);
        repeat (10) tick();
        n_checks++; if (SIGN8 !== 8'h03) $display("FAIL midwarm_sign: got %h want 03", SIGN8); else n_pass++;
        RST = 1'b0;
        #1;
        n_checks++; if (SIGN8 !== 8'h00) $display("FAIL midwarm_async_sign: got %h want 00", SIGN8); else n_pass++;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_warm_timing();
        int unsigned cnt;
        load_key(K1, IV1, 0);
        cnt = 0;
        while (SIGN8 === 8'h03 && cnt < 1000) begin
            cnt++;
            tick();
        end
        n_checks++; if (cnt != 144) $display("FAIL warm_cycles: got %0d want 144", cnt); else n_pass++;
        n_checks++; if (SIGN8 !== 8'h05) $display("FAIL warm_run_sign: got %h want 05", SIGN8); else n_pass++;
        n_checks++; if (READY8 !== 1'b1) $display("FAIL warm_run_ready: got %b want 1", READY8); else n_pass++;
    endtask

    task automatic test_width_equiv();
        logic [7:0] eb [64];
        logic [7:0] acc;
        logic [7:0] e;
        int unsigned nb;
        model_load(K1, IV1);
        for (int i = 0; i < 64; i++) model_byte(eb[i]);
        wait_run1("width_run1");
        acc = '0;
        nb = 0;
        READ8 = 1'b1;
        READ1 = 1'b1;
        for (int c = 0; c < 520; c++) begin
            if (c < 64) begin
                STB_DATA8 = 1'b1; DATA8 = 8'h00; q8.push_back(eb[c]);
            end else begin
                STB_DATA8 = 1'b0;
            end
            if (c < 512) begin
                STB_DATA1 = 1'b1; DATA1 = 1'b0;
                if (c % 8 == 0) q1.push_back(eb[c/8]);
            end else begin
                STB_DATA1 = 1'b0;
            end
            tick();
            if (STB_READ8 === 1'b1) begin
                n_checks++;
                if (q8.size() == 0) begin
                    $display("FAIL width_w8: unexpected word %h", DOUT8);
                end else begin
                    e = q8.pop_front();
                    if (DOUT8 !== e) $display("FAIL width_w8: got %h want %h", DOUT8, e);
                    else n_pass++;
                end
            end
            if (STB_READ1 === 1'b1) begin
                acc = {acc[6:0], DOUT1[0]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    n_checks++;
                    if (q1.size() == 0) begin
                        $display("FAIL width_w1: unexpected byte %h", acc);
                    end else begin
                        e = q1.pop_front();
                        if (acc !== e) $display("FAIL width_w1: got %h want %h", acc, e);
                        else n_pass++;
                    end
                end
            end
        end
        n_checks++; if (q8.size() != 0) $display("FAIL width_w8_drain: got %0d left want 0", q8.size()); else n_pass++;
        n_checks++; if (q1.size() != 0) $display("FAIL width_w1_drain: got %0d left want 0", q1.size()); else n_pass++;
    endtask

    task automatic test_round_trip();
        logic [7:0] ks0, ks1, c0, c1, e, kx;
        load_key(K2, IV2, 0);
        model_load(K2, IV2);
        wait_run8("rt_run_a");
        model_byte(ks0);
        model_byte(ks1);
        c0 = 8'hA5 ^ ks0;
        c1 = 8'h3C ^ ks1;
        READ8 = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) begin
                    STB_DATA8 = 1'b1;
                    DATA8 = (pass == 0) ? 8'hA5 : c0;
                    q8.push_back((pass == 0) ? c0 : 8'hA5);
                end else if (c == 1) begin
                    STB_DATA8 = 1'b1;
                    DATA8 = (pass == 0) ? 8'h3C : c1;
                    q8.push_back((pass == 0) ? c1 : 8'h3C);
                end else begin
                    STB_DATA8 = 1'b0;
                end
                tick();
                if (STB_READ8 === 1'b1) begin
                    n_checks++;
                    if (q8.size() == 0) begin
                        $display("FAIL round_trip%0d: unexpected word %h", pass, DOUT8);
                    end else begin
                        e = q8.pop_front();
                        if (DOUT8 !== e) $display("FAIL round_trip%0d: got %h want %h", pass, DOUT8, e);
                        else n_pass++;
                    end
                end
            end
            n_checks++; if (q8.size() != 0) $display("FAIL round_trip%0d_drain: got %0d left want 0", pass, q8.size()); else n_pass++;
            if (pass == 0) begin
                load_key(K2, IV2, 0);
                model_load(K2, IV2);
                model_byte(kx);
                model_byte(kx);
                wait_run8("rt_run_b");
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ka, kb, ea, e;
        model_byte(ka);
        ea = 8'h11 ^ ka;
        READ8 = 1'b0;
        STB_DATA8 = 1'b1;
        DATA8 = 8'h11;
        tick();
        STB_DATA8 = 1'b0;
        n_checks++; if (STB_READ8 !== 1'b1) $display("FAIL bp_first_stb: got %b want 1", STB_READ8); else n_pass++;
        n_checks++; if (DOUT8 !== ea) $display("FAIL bp_first_data: got %h want %h", DOUT8, ea); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                STB_DATA8 = 1'b1;
                DATA8 = 8'h77;
            end
            tick();
            STB_DATA8 = 1'b0;
            n_checks++; if (DOUT8 !== ea) $display("FAIL bp_hold_data%0d: got %h want %h", i, DOUT8, ea); else n_pass++;
            n_checks++; if (READY8 !== 1'b0) $display("FAIL bp_hold_ready%0d: got %b want 0", i, READY8); else n_pass++;
        end
        n_checks++; if (SIGN8 !== 8'h0D) $display("FAIL bp_overrun_sign: got %h want 0d", SIGN8); else n_pass++;
        model_byte(kb);
        e = 8'h22 ^ kb;
        READ8 = 1'b1;
        STB_DATA8 = 1'b1;
        DATA8 = 8'h22;
        #1;
        n_checks++; if (READY8 !== 1'b1) $display("FAIL bp_ready_on_read: got %b want 1", READY8); else n_pass++;
        tick();
        STB_DATA8 = 1'b0;
        n_checks++; if (STB_READ8 !== 1'b1) $display("FAIL bp_next_stb: got %b want 1", STB_READ8); else n_pass++;
        n_checks++; if (DOUT8 !== e) $display("FAIL bp_next_data: got %h want %h", DOUT8, e); else n_pass++;
        tick();
        n_checks++; if (STB_READ8 !== 1'b0) $display("FAIL bp_stb_clear: got %b want 0", STB_READ8); else n_pass++;
        n_checks++; if (SIGN8 !== 8'h0D) $display("FAIL bp_sticky: got %h want 0d", SIGN8); else n_pass++;
    endtask

    task automatic test_rekey_run();
        logic [7:0] k0, e;
        READ8 = 1'b1;
        KEY = K3[0];
        STB_KEY = 1'b1;
        STB_DATA8 = 1'b1;
        DATA8 = 8'h55;
        tick();
        STB_KEY = 1'b0;
        STB_DATA8 = 1'b0;
        n_checks++; if (SIGN8 !== 8'h00) $display("FAIL rekey_sign: got %h want 00", SIGN8); else n_pass++;
        n_checks++; if (STB_READ8 !== 1'b0) $display("FAIL rekey_stb_read: got %b want 0", STB_READ8); else n_pass++;
        n_checks++; if (READY8 !== 1'b0) $display("FAIL rekey_ready: got %b want 0", READY8); else n_pass++;
        // The rekey strobe bit is K1; finish the load and check the resulting keystream.
        load_key(K3, IV3, 1);
        model_load(K3, IV3);
        wait_run8("rekey_run");
        model_byte(k0);
        e = 8'h9E ^ k0;
        STB_DATA8 = 1'b1;
        DATA8 = 8'h9E;
        tick();
        STB_DATA8 = 1'b0;
        n_checks++; if (DOUT8 !== e) $display("FAIL rekey_stream: got %h want %h", DOUT8, e); else n_pass++;
        n_checks++; if (SIGN8 !== 8'h05) $display("FAIL rekey_final_sign: got %h want 05", SIGN8); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_warm_timing();
        test_width_equiv();
        test_round_trip();
        test_backpressure();
        test_rekey_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trivium_stream_xor.md
# trivium_stream_xor

Parametrised Trivium stream-cipher engine, the next generation of the byte-wide cipher core. It loads an 80-bit key and an 80-bit IV serially, runs the initialisation warm-up, then XORs DATA_W-bit words with keystream generated DATA_W bits per clock. It adds output backpressure and a status register, and it sits between the key/data producer and the consumer in the cipher datapath.

## Interface
- DATA_W, 8, word width and keystream bits generated per clock; legal values 1, 8, 16, 32, 64.
- WARM_ROUNDS, 4, warm-up length in units of 288 state updates; (WARM_ROUNDS*288) % DATA_W must be 0.
- CLK  in  1  sole clock, all logic on the rising edge.
- RST  in  1  reset, asynchronous assert, active-low.
- KEY  in  1  serial key/IV bit, sampled when STB_KEY=1.
- STB_KEY  in  1  key/IV bit strobe.
- DATA  in  DATA_W  plaintext/ciphertext word, sampled when STB_DATA=1 and READY=1.
- STB_DATA  in  1  input word strobe.
- READ  in  1  consumer accepts DATA_OUT this cycle.
- DATA_OUT  out  DATA_W  DATA XOR keystream, registered.
- STB_READ  out  1  DATA_OUT valid; held until READ.
- READY  out  1  input word will be accepted this cycle.
- SIGN_REG  out  8  status: [0] LOADED, [1] WARM, [2] RUN, [3] OVERRUN (sticky), [7:4] zero.

## Operation
- States: IDLE, LOAD, WARM, RUN.
- IDLE: on STB_KEY, go to LOAD. The strobed bit becomes K1 (s1). The bit counter is set to 1.
- LOAD: each STB_KEY shifts one bit in. Bits 1–80 go to K1..K80 (s1..s80). Bits 81–160 go to IV1..IV80 (s94..s173). All remaining state bits are 0, except s286..s288, which are 1.
- LOAD: gaps between strobes are allowed. After the 160th bit: LOADED=1, go to WARM, and clear the warm counter.
- WARM: apply DATA_W Trivium updates per cycle. Discard all output bits. Run for WARM_ROUNDS*288/DATA_W cycles (144 for the defaults), then go to RUN.
- Per-bit update, standard Trivium (all additions are XOR):
  - t1=s66+s93, t2=s162+s177, t3=s243+s288, z=t1+t2+t3.
  - t1+=s91·s92+s171, t2+=s175·s176+s264, t3+=s286·s287+s69.
  - Shift in: s1←t3, s94←t1, s178←t2.
- RUN: on STB_DATA with READY=1, compute DATA_W keystream bits in one cycle and advance the state by DATA_W.
  - The first-generated bit z0 XORs DATA[DATA_W-1]; zi XORs DATA[DATA_W-1-i] (MSB first).
  - The state advances only on accepted words.
- READY = (state==RUN) && (!STB_READ || READ).
- STB_DATA while READY=0: the word is dropped, the state does not advance, and OVERRUN←1.
- STB_KEY in WARM or RUN aborts the current session. Go to LOAD, clear LOADED and OVERRUN, and take the bit as K1. STB_READ and DATA_OUT are unchanged until READ.
- Simultaneous STB_KEY and STB_DATA in RUN: the rekey wins and the data word is dropped. OVERRUN is not set.
- RST low at any time: all state returns to reset immediately, including mid-load and mid-warm-up.
- SIGN_REG: [0] LOADED, [1] state==WARM, [2] state==RUN, [3] OVERRUN.

## Timing
- Reset values: DATA_OUT=0, STB_READ=0, READY=0, SIGN_REG=0x00, state IDLE, Trivium state all zero.
- Strobe to output: STB_DATA accepted at edge n gives DATA_OUT and STB_READ=1 after edge n+1.
- Throughput: one word per cycle while READ=1.
- STB_READ clears on the edge where READ=1 unless a new word is accepted on the same edge.
- Last key bit to RUN: the 160th strobe at edge n gives WARM from n+1, and RUN/READY=1 from n+1+WARM_ROUNDS*288/DATA_W.
- SIGN_REG is registered and updates on the same edge as the state register.

## Structure
- Shared package trivium_pkg holds:
  - KEY_BITS=80, IV_BITS=80, STATE_BITS=288.
  - State enum.
  - SIGN_REG bit indices.
  - Tap position constants.
- Sub-module trivium_step: combinational, parameter N. It takes a 288-bit state and returns the next state after N updates plus an N-bit keystream (z0 at the MSB). It is used for both WARM and RUN.
- Top-level module: FSM, load/warm counters, output register, status.

## Test plan
- **Reset mid-load:** 50 key bits, then RST low for 1 cycle → SIGN_REG=0x00, READY=0. A following full 160-bit load reaches RUN normally.
- **Warm-up timing (DATA_W=8):** 160 bits loaded → SIGN_REG=0x03 for exactly 144 cycles, then 0x05 with READY=1.
- **Width equivalence:** the same key/IV in DATA_W=1 and DATA_W=8 instances with DATA=0 → eight serial output bits packed MSB-first equal each byte DATA_OUT. Both also match a C/SV reference model over 64 bytes.
- **Round trip:** encrypt 0xA5 then 0x3C, reload the same key/IV, and feed the ciphertexts back → DATA_OUT = 0xA5 then 0x3C.
- **Backpressure:** STB_READ=1 with READ=0 for 3 cycles → DATA_OUT stable and READY=0. A STB_DATA pulse in that window sets SIGN_REG=0x0D. The next accepted word uses the unadvanced keystream.
- **Rekey in RUN:** STB_KEY together with STB_DATA → state LOAD, SIGN_REG=0x00, no STB_READ for the data word, and no OVERRUN.
